// File: rtl/data_ram_pkg.sv
// Shared types and default sizing for the data RAM controller.
package data_ram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

endpackage

// File: rtl/dram_array.sv
// Single-port-pair RAM: one synchronous write port, one synchronous read port, no reset.
// DATA_RAM_WR_FWD_EN: same-cycle same-address read returns the incoming write data.
module dram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
`ifdef DATA_RAM_WR_FWD_EN
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
`else
      rdata <= mem[raddr];
`endif
    end
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Image load / random access / streamed dump controller around a dram_array.
// Read/write collision behaviour follows DATA_RAM_WR_FWD_EN (see dram_array).
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for load_start or dump_start
// LOAD    | accept ld_data stream into words 0..DEPTH-1
// RUN     | random read/write through addr/din/dout
// DUMP    | stream words 0..DEPTH-1 out on dp_* with backpressure
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dump_start,
  output logic              dp_valid,
  output logic [DATA_W-1:0] dp_data,
  output logic              dp_last,
  input  logic              dp_ready,
  output logic              wr_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] ld_ptr, dp_ptr;
  logic              ld_hs, ld_last, dp_hs, dp_fin, dp_issue;
  logic              ld_done_q, wr_done_q, dp_valid_q, dp_last_q, rd_pend;
  logic [DATA_W-1:0] dout_q;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  dram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt = ST_LOAD;
        end else if (dump_start) begin
          state_nxt = ST_DUMP;
        end
      end
      ST_LOAD: if (ld_hs && ld_last) state_nxt = ST_RUN;
      ST_RUN:  if (dump_start) state_nxt = ST_DUMP;
      ST_DUMP: if (dp_fin) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Dump fetch is pipelined: a new read issues whenever the output slot is empty or draining.
  always_comb begin
    ld_ready  = (state == ST_LOAD);
    busy      = (state == ST_LOAD) || (state == ST_DUMP);
    ld_hs     = ld_valid && ld_ready;
    ld_last   = (ld_ptr == LAST_ADDR);
    dp_hs     = dp_valid_q && dp_ready;
    dp_fin    = dp_hs && dp_last_q;
    dp_issue  = (state == ST_DUMP) && (!dp_valid_q || (dp_hs && !dp_last_q));
    mem_we    = 1'b0;
    mem_waddr = ld_ptr;
    mem_wdata = ld_data;
    mem_re    = 1'b0;
    mem_raddr = dp_ptr;
    case (state)
      ST_LOAD: begin
        mem_we = ld_hs;
      end
      ST_RUN: begin
        mem_we    = write;
        mem_waddr = addr;
        mem_wdata = din;
        mem_re    = read;
        mem_raddr = addr;
      end
      ST_DUMP: begin
        mem_re = dp_issue;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ptr     <= '0;
      dp_ptr     <= '0;
      ld_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_last_q  <= 1'b0;
      rd_pend    <= 1'b0;
      dout_q     <= '0;
    end else begin
      ld_done_q <= ld_hs && ld_last;
      wr_done_q <= dp_fin;
      rd_pend   <= (state == ST_RUN) && read;
      if (ld_hs) begin
        ld_ptr <= ld_ptr + ADDR_W'(1);
      end
      if (dp_issue) begin
        dp_ptr     <= dp_ptr + ADDR_W'(1);
        dp_valid_q <= 1'b1;
        dp_last_q  <= (dp_ptr == LAST_ADDR);
      end else if (dp_fin) begin
        dp_valid_q <= 1'b0;
        dp_last_q  <= 1'b0;
      end
      if (rd_pend) begin
        dout_q <= mem_rdata;
      end
    end
  end

  // The array read register is shared with dump, so dout shows it only in the cycle after a read.
  assign dout       = rd_pend ? mem_rdata : dout_q;
  assign dout_valid = rd_pend;
  assign dp_valid   = dp_valid_q;
  assign dp_data    = dp_valid_q ? mem_rdata : '0;
  assign dp_last    = dp_last_q;
  assign ld_done    = ld_done_q;
  assign wr_done    = wr_done_q;

endmodule
